// File: rtl/port_input_cond_if.sv
`default_nettype none
// ============================================================================
// Module  : port_input_cond_if
// Brief   : Pad-side and register-side signal bundle for port_input_cond.
// Revision: 1.0 - initial release
// ============================================================================
interface port_input_cond_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] input_en;
  logic [WIDTH-1:0] irq_rise_en;
  logic [WIDTH-1:0] irq_fall_en;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] flag;
  logic [WIDTH-1:0] ovf;
  logic             irq;

  modport master (
    output pad_in, input_en, irq_rise_en, irq_fall_en, flag_clr,
    input  in_val, rise_pulse, fall_pulse, flag, ovf, irq
  );

  modport slave (
    input  pad_in, input_en, irq_rise_en, irq_fall_en, flag_clr,
    output in_val, rise_pulse, fall_pulse, flag, ovf, irq
  );
endinterface
`default_nettype wire

// File: rtl/port_input_cond.sv
`default_nettype none
// ============================================================================
// Module  : port_input_cond
// Brief   : Per-pin synchroniser, debounce, edge detect and sticky W1C flags.
// Revision: 1.0 - initial release
// ============================================================================
module port_input_cond #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire                 clk,
  input  wire                 rst,
  port_input_cond_if.slave    bus
);
  localparam int             c_CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_in_val;
  logic [WIDTH-1:0] r_rise_pend;
  logic [WIDTH-1:0] r_fall_pend;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_flag;
  logic [WIDTH-1:0] r_ovf;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_set;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= bus.pad_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    logic [c_CW-1:0] r_cnt;
    logic            w_diff;

    assign w_diff   = w_s[i] ^ r_in_val[i];
    assign w_acc[i] = bus.input_en[i] & w_diff & (r_cnt == c_CNT_MAX);

    // Any agreement, disable or acceptance restarts the stability window.
    always_ff @(posedge clk) begin
      if (rst || !bus.input_en[i] || !w_diff || w_acc[i]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_set = (r_rise & bus.irq_rise_en) | (r_fall & bus.irq_fall_en);

  // Pulses come from accepted changes only, so the forced drop on disable
  // never produces a fall pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_val    <= '0;
      r_rise_pend <= '0;
      r_fall_pend <= '0;
      r_rise      <= '0;
      r_fall      <= '0;
      r_flag      <= '0;
      r_ovf       <= '0;
    end else begin
      r_in_val    <= bus.input_en & ((w_acc & w_s) | (~w_acc & r_in_val));
      r_rise_pend <= w_acc & w_s;
      r_fall_pend <= w_acc & ~w_s;
      r_rise      <= r_rise_pend;
      r_fall      <= r_fall_pend;
      r_flag      <= w_set | (r_flag & ~bus.flag_clr);
      r_ovf       <= ~bus.flag_clr & (r_ovf | (w_set & r_flag));
    end
  end

  assign bus.in_val     = r_in_val;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.flag       = r_flag;
  assign bus.ovf        = r_ovf;
  assign bus.irq        = |r_flag;
endmodule
`default_nettype wire

// File: tb/tb_port_input_cond.sv
`default_nettype none
// ============================================================================
// Module  : tb_port_input_cond
// Brief   : Directed self-checking bench for port_input_cond (default params).
// Revision: 1.0 - initial release
// ============================================================================
module tb_port_input_cond;
  logic clk;
  logic rst;
  int   r_checks;
  int   r_errors;

  port_input_cond_if #(.WIDTH(8)) bus ();

  port_input_cond #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr(input logic [7:0] v);
    bus.flag_clr = v;
    tick(1);
    bus.flag_clr = 8'h00;
  endtask

  initial begin
    r_checks        = 0;
    r_errors        = 0;
    rst             = 1'b1;
    bus.pad_in      = 8'h00;
    bus.input_en    = 8'hFF;
    bus.irq_rise_en = 8'h01;
    bus.irq_fall_en = 8'h00;
    bus.flag_clr    = 8'h00;
    tick(2);
    check("rst_in_val", bus.in_val, 8'h00);
    check("rst_flag",   bus.flag,   8'h00);
    check("rst_ovf",    bus.ovf,    8'h00);
    check("rst_irq",    bus.irq,    1'b0);
    rst = 1'b0;
    tick(2);

    // 1: clean rise on pin 0, six-cycle latency then pulse then flag
    bus.pad_in = 8'h01;
    tick(5);
    check("t1_in_val_e5", bus.in_val, 8'h00);
    tick(1);
    check("t1_in_val_e6", bus.in_val, 8'h01);
    check("t1_rise_e6",   bus.rise_pulse, 8'h00);
    tick(1);
    check("t1_rise_e7",   bus.rise_pulse, 8'h01);
    check("t1_flag_e7",   bus.flag, 8'h00);
    tick(1);
    check("t1_rise_e8",   bus.rise_pulse, 8'h00);
    check("t1_flag_e8",   bus.flag, 8'h01);
    check("t1_irq_e8",    bus.irq, 1'b1);

    // 2: 3-cycle glitch on pin 3 rejected, 4-cycle accepted
    bus.irq_rise_en = 8'hFF;
    bus.pad_in = 8'h09;
    tick(3);
    bus.pad_in = 8'h01;
    tick(8);
    check("t2_glitch_in_val", bus.in_val, 8'h01);
    check("t2_glitch_flag",   bus.flag, 8'h01);
    bus.pad_in = 8'h09;
    tick(4);
    bus.pad_in = 8'h01;
    tick(2);
    check("t2_acc_in_val", bus.in_val, 8'h09);
    tick(1);
    check("t2_acc_rise", bus.rise_pulse, 8'h08);
    tick(1);
    check("t2_acc_flag", bus.flag, 8'h09);
    tick(12);
    check("t2_fall_back", bus.in_val, 8'h01);
    pulse_clr(8'hFF);
    check("t2_clr_flag", bus.flag, 8'h00);

    // 3: overflow on second rise, then set-vs-clear collision
    bus.pad_in = 8'h00; tick(8);
    bus.pad_in = 8'h01; tick(8);
    check("t3_flag_first", bus.flag, 8'h01);
    check("t3_ovf_first",  bus.ovf,  8'h00);
    bus.pad_in = 8'h00; tick(8);
    bus.pad_in = 8'h01; tick(8);
    check("t3_ovf_second", bus.ovf, 8'h01);
    bus.pad_in = 8'h00; tick(8);
    bus.pad_in = 8'h01; tick(7);
    check("t3_rise_pre", bus.rise_pulse, 8'h01);
    pulse_clr(8'h01);
    check("t3_coll_flag", bus.flag, 8'h01);
    check("t3_coll_ovf",  bus.ovf,  8'h00);

    // 4: forced disable gives no fall pulse/flag; re-enable re-debounces
    bus.pad_in = 8'hFF; tick(10);
    check("t4_in_val_ff", bus.in_val, 8'hFF);
    pulse_clr(8'hFF);
    bus.irq_fall_en = 8'hFF;
    bus.input_en = 8'h00;
    tick(1);
    check("t4_dis_in_val", bus.in_val, 8'h00);
    tick(1);
    check("t4_dis_fall", bus.fall_pulse, 8'h00);
    tick(2);
    check("t4_dis_flag", bus.flag, 8'h00);
    bus.input_en = 8'hFF;
    tick(3);
    check("t4_en_e3", bus.in_val, 8'h00);
    tick(1);
    check("t4_en_e4", bus.in_val, 8'hFF);
    tick(1);
    check("t4_en_rise", bus.rise_pulse, 8'hFF);
    tick(1);
    check("t4_en_flag", bus.flag, 8'hFF);

    // 6: all pins fall, flags set, partial clear keeps irq
    pulse_clr(8'hFF);
    bus.irq_rise_en = 8'h00;
    bus.pad_in = 8'h00;
    tick(7);
    check("t6_fall", bus.fall_pulse, 8'hFF);
    tick(1);
    check("t6_flag", bus.flag, 8'hFF);
    check("t6_irq",  bus.irq, 1'b1);
    pulse_clr(8'h0F);
    check("t6_clr_flag", bus.flag, 8'hF0);
    check("t6_clr_irq",  bus.irq, 1'b1);

    // 5: reset mid-debounce on pin 7 with flag=80
    pulse_clr(8'hFF);
    bus.irq_rise_en = 8'h80;
    bus.irq_fall_en = 8'h00;
    bus.pad_in = 8'h80; tick(8);
    bus.pad_in = 8'h00; tick(8);
    check("t5_flag_setup", bus.flag, 8'h80);
    bus.pad_in = 8'h80; tick(4);
    rst = 1'b1;
    tick(1);
    check("t5_rst_in_val", bus.in_val, 8'h00);
    check("t5_rst_rise",   bus.rise_pulse, 8'h00);
    check("t5_rst_fall",   bus.fall_pulse, 8'h00);
    check("t5_rst_flag",   bus.flag, 8'h00);
    check("t5_rst_ovf",    bus.ovf, 8'h00);
    check("t5_rst_irq",    bus.irq, 1'b0);
    rst = 1'b0;
    tick(5);
    check("t5_rel_e5", bus.in_val, 8'h00);
    tick(1);
    check("t5_rel_e6", bus.in_val, 8'h80);

    $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
    $finish;
  end
endmodule
`default_nettype wire
